// File: rtl/alu_decode_stage.sv
// ALU decode pipeline stage: decodes the data-processing command, evaluates the ARM
// condition against the NZCV register and presents the result behind a valid/ready slot.
module alu_decode_stage #(
    parameter int unsigned CTRL_W      = 3,
    parameter bit          SUPPORT_EXT = 1'b1,
    parameter bit          FLAG_FWD    = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              ALUop,
    input  logic [3:0]        funct_cmd,
    input  logic              funct_s,
    input  logic [3:0]        cond,
    input  logic [3:0]        flag_in,
    input  logic [1:0]        flag_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ALUcontrol,
    output logic [1:0]        flagW,
    output logic              no_write,
    output logic              cond_ex,
    output logic              illegal,
    output logic [3:0]        flags
);

    localparam int unsigned CODE_W = 3;

    localparam logic [CODE_W-1:0] OP_ADD = 3'd0;
    localparam logic [CODE_W-1:0] OP_SUB = 3'd1;
    localparam logic [CODE_W-1:0] OP_AND = 3'd2;
    localparam logic [CODE_W-1:0] OP_ORR = 3'd3;
    localparam logic [CODE_W-1:0] OP_EOR = 3'd4;
    localparam logic [CODE_W-1:0] OP_BIC = 3'd5;
    localparam logic [CODE_W-1:0] OP_MOV = 3'd6;

    localparam logic [1:0] FW_ARITH = 2'b11;
    localparam logic [1:0] FW_LOGIC = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_TEQ = 4'b1001;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_CMN = 4'b1011;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;
    localparam logic [3:0] CMD_BIC = 4'b1110;

    logic              out_valid_q, out_valid_d;
    logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
    logic [1:0]        flagw_q, flagw_d;
    logic              no_write_q, no_write_d;
    logic              cond_ex_q, cond_ex_d;
    logic              illegal_q, illegal_d;
    logic [3:0]        flags_q, flags_d;

    logic [CODE_W-1:0] dec_code;
    logic [1:0]        dec_fw_pre;
    logic              dec_cmp, dec_ext, dec_bad;
    logic [1:0]        eff_nz, eff_cv;
    logic              f_n, f_z, f_c, f_v, cond_pass;
    logic [CODE_W-1:0] res_code;
    logic [1:0]        res_fw;
    logic              res_nw, res_cex, res_ill;
    logic              accept;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Command field -> ALU op, flag class, compare and extended-set membership
    always_comb begin
        dec_code   = OP_ADD;
        dec_fw_pre = FW_LOGIC;
        dec_cmp    = 1'b0;
        dec_ext    = 1'b1;
        dec_bad    = 1'b0;
        case (funct_cmd)
            CMD_ADD: begin dec_code = OP_ADD; dec_fw_pre = FW_ARITH; dec_ext = 1'b0; end
            CMD_SUB: begin dec_code = OP_SUB; dec_fw_pre = FW_ARITH; dec_ext = 1'b0; end
            CMD_AND: begin dec_code = OP_AND; dec_ext = 1'b0; end
            CMD_ORR: begin dec_code = OP_ORR; dec_ext = 1'b0; end
            CMD_EOR: dec_code = OP_EOR;
            CMD_BIC: dec_code = OP_BIC;
            CMD_MOV: dec_code = OP_MOV;
            CMD_CMP: begin dec_code = OP_SUB; dec_fw_pre = FW_ARITH; dec_cmp = 1'b1; end
            CMD_CMN: begin dec_code = OP_ADD; dec_fw_pre = FW_ARITH; dec_cmp = 1'b1; end
            CMD_TST: begin dec_code = OP_AND; dec_cmp = 1'b1; end
            CMD_TEQ: begin dec_code = OP_EOR; dec_cmp = 1'b1; end
            default: dec_bad = 1'b1;
        endcase
    end

    // Flags seen by the condition: optionally bypass the write landing this cycle
    always_comb begin
        eff_nz = flags_q[3:2];
        eff_cv = flags_q[1:0];
        if (FLAG_FWD && flag_we[1]) eff_nz = flag_in[3:2];
        if (FLAG_FWD && flag_we[0]) eff_cv = flag_in[1:0];
    end

    assign {f_n, f_z} = eff_nz;
    assign {f_c, f_v} = eff_cv;

    always_comb begin
        cond_pass = 1'b1;
        case (cond)
            4'h0:    cond_pass = f_z;
            4'h1:    cond_pass = !f_z;
            4'h2:    cond_pass = f_c;
            4'h3:    cond_pass = !f_c;
            4'h4:    cond_pass = f_n;
            4'h5:    cond_pass = !f_n;
            4'h6:    cond_pass = f_v;
            4'h7:    cond_pass = !f_v;
            4'h8:    cond_pass = f_c && !f_z;
            4'h9:    cond_pass = !f_c || f_z;
            4'hA:    cond_pass = (f_n == f_v);
            4'hB:    cond_pass = (f_n != f_v);
            4'hC:    cond_pass = !f_z && (f_n == f_v);
            4'hD:    cond_pass = f_z || (f_n != f_v);
            default: cond_pass = 1'b1;
        endcase
    end

    // Final result; illegal encodings collapse to a harmless ADD that writes nothing
    always_comb begin
        res_code = OP_ADD;
        res_fw   = 2'b00;
        res_nw   = 1'b0;
        res_cex  = cond_pass;
        res_ill  = 1'b0;
        if (ALUop) begin
            res_ill = dec_bad || (dec_cmp && !funct_s) || (dec_ext && !SUPPORT_EXT);
            if (res_ill) begin
                res_nw  = 1'b1;
                res_cex = 1'b0;
            end else begin
                res_code = dec_code;
                res_nw   = dec_cmp;
                res_fw   = (funct_s && cond_pass) ? dec_fw_pre : 2'b00;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        alu_ctrl_d  = alu_ctrl_q;
        flagw_d     = flagw_q;
        no_write_d  = no_write_q;
        cond_ex_d   = cond_ex_q;
        illegal_d   = illegal_q;
        flags_d     = flags_q;
        if (accept) begin
            out_valid_d = 1'b1;
            alu_ctrl_d  = CTRL_W'(res_code);
            flagw_d     = res_fw;
            no_write_d  = res_nw;
            cond_ex_d   = res_cex;
            illegal_d   = res_ill;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (flag_we[1]) flags_d[3:2] = flag_in[3:2];
        if (flag_we[0]) flags_d[1:0] = flag_in[1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            alu_ctrl_q  <= '0;
            flagw_q     <= 2'b00;
            no_write_q  <= 1'b0;
            cond_ex_q   <= 1'b0;
            illegal_q   <= 1'b0;
            flags_q     <= 4'b0000;
        end else begin
            out_valid_q <= out_valid_d;
            alu_ctrl_q  <= alu_ctrl_d;
            flagw_q     <= flagw_d;
            no_write_q  <= no_write_d;
            cond_ex_q   <= cond_ex_d;
            illegal_q   <= illegal_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign ALUcontrol = alu_ctrl_q;
    assign flagW      = flagw_q;
    assign no_write   = no_write_q;
    assign cond_ex    = cond_ex_q;
    assign illegal    = illegal_q;
    assign flags      = flags_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: a full-featured forwarding instance and a
// reduced (base command set, registered-flag) instance share the same stimulus.
module tb_alu_decode_stage;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       ALUop = 1'b0;
    logic [3:0] funct_cmd = 4'h0;
    logic       funct_s = 1'b0;
    logic [3:0] cond = 4'hE;
    logic [3:0] flag_in = 4'h0;
    logic [1:0] flag_we = 2'b00;
    logic       out_ready = 1'b1;

    logic       in_ready_a, out_valid_a, no_write_a, cond_ex_a, illegal_a;
    logic [2:0] ALUcontrol_a;
    logic [1:0] flagW_a;
    logic [3:0] flags_a;
    logic       in_ready_b, out_valid_b, no_write_b, cond_ex_b, illegal_b;
    logic [1:0] ALUcontrol_b;
    logic [1:0] flagW_b;
    logic [3:0] flags_b;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] sbq_a[$];
    logic [7:0] sbq_b[$];
    logic [3:0] flags_m = 4'h0;
    bit         rnd_en = 1'b0;

    always #5 clk = ~clk;

    alu_decode_stage #(.CTRL_W(3), .SUPPORT_EXT(1'b1), .FLAG_FWD(1'b1)) u_dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .ALUop(ALUop), .funct_cmd(funct_cmd), .funct_s(funct_s), .cond(cond),
        .flag_in(flag_in), .flag_we(flag_we), .out_valid(out_valid_a), .out_ready(out_ready),
        .ALUcontrol(ALUcontrol_a), .flagW(flagW_a), .no_write(no_write_a),
        .cond_ex(cond_ex_a), .illegal(illegal_a), .flags(flags_a)
    );

    alu_decode_stage #(.CTRL_W(2), .SUPPORT_EXT(1'b0), .FLAG_FWD(1'b0)) u_dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .ALUop(ALUop), .funct_cmd(funct_cmd), .funct_s(funct_s), .cond(cond),
        .flag_in(flag_in), .flag_we(flag_we), .out_valid(out_valid_b), .out_ready(out_ready),
        .ALUcontrol(ALUcontrol_b), .flagW(flagW_b), .no_write(no_write_b),
        .cond_ex(cond_ex_b), .illegal(illegal_b), .flags(flags_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: {ctrl[2:0], flagW[1:0], no_write, cond_ex, illegal}
    function automatic logic [7:0] model(input logic op, input logic [3:0] cmd, input logic s,
                                         input logic [3:0] cnd, input logic [3:0] f, input bit ext_en);
        logic n, z, c, v, cp, cmp, ext, bad;
        logic [2:0] code;
        logic [1:0] kind;
        {n, z, c, v} = f;
        case (cnd)
            4'h0: cp = z;              4'h1: cp = !z;
            4'h2: cp = c;              4'h3: cp = !c;
            4'h4: cp = n;              4'h5: cp = !n;
            4'h6: cp = v;              4'h7: cp = !v;
            4'h8: cp = c & !z;         4'h9: cp = !c | z;
            4'hA: cp = (n == v);       4'hB: cp = (n != v);
            4'hC: cp = !z & (n == v);  4'hD: cp = z | (n != v);
            default: cp = 1'b1;
        endcase
        bad = 1'b0; cmp = 1'b0; ext = 1'b1; code = 3'd0; kind = 2'b10;
        case (cmd)
            4'b0100: begin code = 3'd0; kind = 2'b11; ext = 1'b0; end
            4'b0010: begin code = 3'd1; kind = 2'b11; ext = 1'b0; end
            4'b0000: begin code = 3'd2; ext = 1'b0; end
            4'b1100: begin code = 3'd3; ext = 1'b0; end
            4'b0001: code = 3'd4;
            4'b1110: code = 3'd5;
            4'b1101: code = 3'd6;
            4'b1010: begin code = 3'd1; kind = 2'b11; cmp = 1'b1; end
            4'b1011: begin code = 3'd0; kind = 2'b11; cmp = 1'b1; end
            4'b1000: begin code = 3'd2; cmp = 1'b1; end
            4'b1001: begin code = 3'd4; cmp = 1'b1; end
            default: bad = 1'b1;
        endcase
        if (!op) return {3'd0, 2'b00, 1'b0, cp, 1'b0};
        if (bad || (cmp && !s) || (ext && !ext_en)) return {3'd0, 2'b00, 1'b1, 1'b0, 1'b1};
        return {code, (s && cp) ? kind : 2'b00, cmp, cp, 1'b0};
    endfunction

    // Scoreboard: pop on drain, push on accept, track the flag register
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sbq_a.delete();
            sbq_b.delete();
            flags_m = 4'h0;
        end else begin
            logic acc;
            logic [3:0] eff;
            acc = in_valid && (sbq_a.size() == 0 || out_ready);
            if (sbq_a.size() != 0 && out_ready) begin
                void'(sbq_a.pop_front());
                if (sbq_b.size() != 0) void'(sbq_b.pop_front());
            end
            if (acc) begin
                eff = {flag_we[1] ? flag_in[3:2] : flags_m[3:2], flag_we[0] ? flag_in[1:0] : flags_m[1:0]};
                sbq_a.push_back(model(ALUop, funct_cmd, funct_s, cond, eff, 1'b1));
                sbq_b.push_back(model(ALUop, funct_cmd, funct_s, cond, flags_m, 1'b0));
            end
            if (flag_we[1]) flags_m[3:2] = flag_in[3:2];
            if (flag_we[0]) flags_m[1:0] = flag_in[1:0];
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("out_valid_a", out_valid_a, sbq_a.size() != 0);
            check("out_valid_b", out_valid_b, sbq_b.size() != 0);
            check("in_ready_a", in_ready_a, sbq_a.size() == 0 || out_ready);
            check("in_ready_b", in_ready_b, sbq_b.size() == 0 || out_ready);
            if (sbq_a.size() != 0)
                check("result_a", {ALUcontrol_a, flagW_a, no_write_a, cond_ex_a, illegal_a}, sbq_a[0]);
            if (sbq_b.size() != 0)
                check("result_b", {1'b0, ALUcontrol_b, flagW_b, no_write_b, cond_ex_b, illegal_b}, sbq_b[0]);
            check("flags_a", flags_a, flags_m);
            check("flags_b", flags_b, flags_m);
        end
    end

    always begin
        @(posedge clk);
        #2;
        if (rnd_en) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic op, input logic [3:0] cmd, input logic s, input logic [3:0] cnd,
                        input logic [3:0] fi, input logic [1:0] fwe);
        logic rdy;
        bit   done;
        done = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; ALUop = op; funct_cmd = cmd; funct_s = s; cond = cnd;
        flag_in = fi; flag_we = fwe;
        for (int i = 0; i < 50 && !done; i++) begin
            rdy = in_ready_a;
            @(posedge clk);
            if (rdy) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n, input logic [3:0] fi, input logic [1:0] fwe);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0; flag_in = fi; flag_we = fwe;
        end
    endtask

    initial begin
        time t0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {out_valid_a, ALUcontrol_a, flagW_a, no_write_a, cond_ex_a, illegal_a, flags_a}, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Forced ADD and the main command map
        send(1'b0, 4'b0100, 1'b1, 4'hE, 4'h0, 2'b00);
        send(1'b1, 4'b0100, 1'b1, 4'hE, 4'h0, 2'b00);
        send(1'b1, 4'b0010, 1'b0, 4'hE, 4'h0, 2'b00);
        send(1'b1, 4'b0000, 1'b1, 4'hE, 4'h0, 2'b00);
        send(1'b1, 4'b1100, 1'b1, 4'hE, 4'h0, 2'b00);
        send(1'b1, 4'b1110, 1'b1, 4'hE, 4'h0, 2'b00);
        send(1'b1, 4'b0001, 1'b1, 4'hE, 4'h0, 2'b00);
        send(1'b1, 4'b1101, 1'b0, 4'hE, 4'h0, 2'b00);
        send(1'b1, 4'b1010, 1'b1, 4'hE, 4'h0, 2'b00);
        send(1'b1, 4'b1010, 1'b0, 4'hE, 4'h0, 2'b00);
        send(1'b1, 4'b1111, 1'b1, 4'hE, 4'h0, 2'b00);
        send(1'b1, 4'b1011, 1'b1, 4'hF, 4'h0, 2'b00);
        send(1'b1, 4'b1000, 1'b1, 4'hE, 4'h0, 2'b00);
        send(1'b1, 4'b1001, 1'b1, 4'hE, 4'h0, 2'b00);
        idle(2, 4'h0, 2'b00);

        // Condition against written flags, then same-cycle write and accept
        idle(1, 4'b0100, 2'b11);
        send(1'b1, 4'b0100, 1'b1, 4'h0, 4'h0, 2'b00);
        send(1'b1, 4'b0100, 1'b1, 4'h1, 4'h0, 2'b00);
        idle(1, 4'b0000, 2'b11);
        send(1'b1, 4'b0100, 1'b1, 4'h0, 4'b0100, 2'b10);
        idle(1, 4'b0000, 2'b11);
        send(1'b1, 4'b0010, 1'b1, 4'hA, 4'b1001, 2'b11);
        send(1'b1, 4'b0010, 1'b1, 4'h8, 4'b0010, 2'b01);
        idle(2, 4'h0, 2'b00);

        // Back-pressure: three stalled cycles, then one transfer per cycle
        @(posedge clk); #1 out_ready = 1'b0;
        fork
            begin
                send(1'b1, 4'b0100, 1'b1, 4'hE, 4'h0, 2'b00);
                send(1'b1, 4'b0010, 1'b1, 4'hE, 4'h0, 2'b00);
                t0 = $time;
                send(1'b1, 4'b1100, 1'b1, 4'hE, 4'h0, 2'b00);
                check("b2b_period", 32'($time - t0), 32'd10);
            end
            begin
                @(posedge clk);
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready_a, 1'b0);
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        idle(2, 4'h0, 2'b00);

        // Asynchronous reset with a held result and all flags set
        @(posedge clk); #1 out_ready = 1'b0;
        send(1'b1, 4'b0100, 1'b1, 4'hE, 4'hF, 2'b11);
        idle(1, 4'h0, 2'b00);
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid", {out_valid_a, out_valid_b}, 2'b00);
        check("async_rst_flags", {flags_a, flags_b}, 8'h00);
        @(posedge clk); #1 reset = 1'b0; out_ready = 1'b1;

        // Random traffic with random back-pressure and flag writes
        @(posedge clk); #1 rnd_en = 1'b1;
        repeat (80) begin
            send(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom), 4'($urandom),
                 4'($urandom), 2'($urandom));
            if ($urandom_range(0, 3) == 0) idle(1, 4'($urandom), 2'($urandom));
        end
        @(posedge clk); #1 rnd_en = 1'b0; out_ready = 1'b1;
        idle(4, 4'h0, 2'b00);
        check("drain_empty", sbq_a.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
